cory_sram_arbn: RTL and testbench

//  N-port round-robin arbiter and sequencer in front of one single-port SRAM.

---
 rtl/cory_sram_arbn_pkg.sv | 21 ++
 rtl/cory_rr_pick.sv | 31 +++
 rtl/cory_sram_arbn.sv | 136 +++++++++++++
 tb/tb_cory_sram_arbn.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cory_sram_arbn_pkg.sv
// Shared helpers for the cory_sram_arbn SRAM arbiter: id width and modulo-N
// index arithmetic used by the picker and the priority pointer.
package cory_sram_arbn_pkg;

    localparam int CORY_N_MAX     = 16;
    localparam int CORY_L_MAX     = 4;

    // Requester id width; a 1-bit id is kept even for degenerate N.
    function automatic int cory_idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // (b + off) mod n for b < n and off <= n, without a divider.
    function automatic int cory_wrap(input int b, input int off, input int n);
        int s;
        s = b + off;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/cory_rr_pick.sv
// Rotate-priority picker: grants the first set request at or after base,
// wrapping modulo N.
module cory_rr_pick
    import cory_sram_arbn_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = cory_idw(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] base,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gid,
    output logic          any
);

    logic [IW-1:0] idx;

    // Scan from the farthest offset down so the nearest set request wins last.
    always_comb begin
        gid = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = IW'(cory_wrap(int'(base), i, N));
            if (req[idx]) gid = idx;
        end
    end

    assign any = |req;
    assign gnt = any ? (N'(1) << gid) : '0;

endmodule

// File: rtl/cory_sram_arbn.sv
// N-port round-robin arbiter with burst hold in front of one single-port SRAM;
// tracks read owners through the SRAM latency and returns data to them.
module cory_sram_arbn
    import cory_sram_arbn_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int A     = 8,
    parameter  int D     = 16,
    parameter  int L     = 1,
    parameter  int BURST = 4,
    localparam int IW    = cory_idw(N)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   i_a_v,
    input  logic [N-1:0]   i_a_we,
    input  logic [N*A-1:0] i_a_addr,
    input  logic [N*D-1:0] i_a_wdata,
    output logic [N-1:0]   o_a_r,
    output logic [N-1:0]   o_a_rv,
    output logic [D-1:0]   o_a_rdata,
    output logic           o_z_cen,
    output logic           o_z_wen,
    output logic [A-1:0]   o_z_addr,
    output logic [D-1:0]   o_z_wdata,
    input  logic [D-1:0]   i_z_rdata,
    input  logic           i_z_r
);

    localparam int CW = $clog2(BURST + 1);

    logic [IW-1:0] pri_q, pri_d;
    logic [IW-1:0] own_q, own_d;
    logic          hold_q, hold_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [N-1:0]  pick_gnt;
    logic [IW-1:0] pick_gid;
    logic          any_v;

    logic          use_own;
    logic [IW-1:0] g;
    logic [N-1:0]  g_oh;
    logic          g_we;
    logic [A-1:0]  g_addr;
    logic [D-1:0]  g_wdata;
    logic          accept;
    logic [CW-1:0] cnt_base;

    logic [L-1:0]  rv_q;
    logic [IW-1:0] rid_q [L];

    cory_rr_pick #(.N(N)) u_pick (
        .req  (i_a_v),
        .base (pri_q),
        .gnt  (pick_gnt),
        .gid  (pick_gid),
        .any  (any_v)
    );

    // The burst owner keeps the grant only while it still presents a request.
    assign use_own  = hold_q & i_a_v[own_q];
    assign g        = use_own ? own_q : pick_gid;
    assign g_oh     = use_own ? (N'(1) << own_q) : pick_gnt;
    assign g_we     = i_a_we[g];
    assign accept   = any_v & i_z_r;
    assign cnt_base = use_own ? cnt_q : '0;

    always_comb begin
        g_addr  = '0;
        g_wdata = '0;
        for (int k = 0; k < N; k++) begin
            if (g_oh[k]) begin
                g_addr  = i_a_addr[k*A +: A];
                g_wdata = i_a_wdata[k*D +: D];
            end
        end
    end

    assign o_a_r     = i_z_r ? g_oh : '0;
    assign o_z_cen   = ~any_v;
    assign o_z_wen   = any_v ? ~g_we : 1'b1;
    assign o_z_addr  = g_addr;
    assign o_z_wdata = g_wdata;

    always_comb begin
        pri_d  = pri_q;
        own_d  = own_q;
        hold_d = hold_q;
        cnt_d  = cnt_q;
        if (accept) begin
            pri_d = IW'(cory_wrap(int'(g), 1, N));
            if (int'(cnt_base) + 1 < BURST) begin
                hold_d = 1'b1;
                own_d  = g;
                cnt_d  = cnt_base + CW'(1);
            end else begin
                hold_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pri_q  <= '0;
            own_q  <= '0;
            hold_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pri_q  <= pri_d;
            own_q  <= own_d;
            hold_q <= hold_d;
            cnt_q  <= cnt_d;
        end
    end

    // Fixed-length owner pipe; i_z_r only gates issue, so this never stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rv_q <= '0;
            for (int k = 0; k < L; k++) rid_q[k] <= '0;
        end else begin
            rv_q[0]  <= accept & ~g_we;
            rid_q[0] <= g;
            for (int k = 1; k < L; k++) begin
                rv_q[k]  <= rv_q[k-1];
                rid_q[k] <= rid_q[k-1];
            end
        end
    end

    assign o_a_rv    = rv_q[L-1] ? (N'(1) << rid_q[L-1]) : '0;
    assign o_a_rdata = rv_q[L-1] ? i_z_rdata : '0;

endmodule

// File: tb/tb_cory_sram_arbn.sv
// Directed bench for cory_sram_arbn: one instance with BURST=1/L=1 and one with
// BURST=4/L=3, each in front of a small behavioural SRAM.
module tb_cory_sram_arbn;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [3:0]  a_v, a_we, a_r, a_rv;
    logic [31:0] a_addr;
    logic [63:0] a_wdata;
    logic [15:0] a_rdata;
    logic        za_cen, za_wen, za_r;
    logic [7:0]  za_addr;
    logic [15:0] za_wdata, za_rdata;

    logic [3:0]  b_v, b_we, b_r, b_rv;
    logic [31:0] b_addr;
    logic [63:0] b_wdata;
    logic [15:0] b_rdata;
    logic        zb_cen, zb_wen, zb_r;
    logic [7:0]  zb_addr;
    logic [15:0] zb_wdata, zb_rdata;

    cory_sram_arbn #(.N(4), .A(8), .D(16), .L(1), .BURST(1)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .i_a_v(a_v), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
        .o_a_r(a_r), .o_a_rv(a_rv), .o_a_rdata(a_rdata),
        .o_z_cen(za_cen), .o_z_wen(za_wen), .o_z_addr(za_addr), .o_z_wdata(za_wdata),
        .i_z_rdata(za_rdata), .i_z_r(za_r)
    );

    cory_sram_arbn #(.N(4), .A(8), .D(16), .L(3), .BURST(4)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .i_a_v(b_v), .i_a_we(b_we), .i_a_addr(b_addr), .i_a_wdata(b_wdata),
        .o_a_r(b_r), .o_a_rv(b_rv), .o_a_rdata(b_rdata),
        .o_z_cen(zb_cen), .o_z_wen(zb_wen), .o_z_addr(zb_addr), .o_z_wdata(zb_wdata),
        .i_z_rdata(zb_rdata), .i_z_r(zb_r)
    );

    // Behavioural SRAMs: contents {A5, addr} after reset, latency 1 and 3.
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    logic [15:0] pb [3];

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= {8'hA5, 8'(i)};
        end else if (!za_cen && za_r) begin
            if (!za_wen) mem_a[za_addr] <= za_wdata;
            else         za_rdata <= mem_a[za_addr];
        end
    end

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= {8'hA5, 8'(i)};
        end else if (!zb_cen && zb_r && !zb_wen) begin
            mem_b[zb_addr] <= zb_wdata;
        end
        pb[0] <= (!zb_cen && zb_r && zb_wen) ? mem_b[zb_addr] : 16'h0BAD;
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign zb_rdata = pb[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [3:0] exp_t2 [10];
    logic [3:0] v_t3   [7];
    logic [3:0] exp_t3 [7];

    initial begin
        exp_t2 = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h4, 4'h4, 4'h4, 4'h4, 4'h1, 4'h1};
        v_t3   = '{4'hA, 4'hA, 4'h8, 4'hA, 4'hA, 4'hA, 4'hA};
        exp_t3 = '{4'h2, 4'h2, 4'h8, 4'h8, 4'h8, 4'h8, 4'h2};

        reset_n = 1'b0;
        a_v = '0; a_we = '0; a_addr = '0; a_wdata = '0; za_r = 1'b1;
        b_v = '0; b_we = '0; b_addr = '0; b_wdata = '0; zb_r = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_a_r",    32'(a_r),    32'h0);
        chk("rst_a_rv",   32'(a_rv),   32'h0);
        chk("rst_a_cen",  32'(za_cen), 32'h1);
        chk("rst_b_rv",   32'(b_rv),   32'h0);
        chk("rst_b_cen",  32'(zb_cen), 32'h1);
        chk("rst_a_rdat", 32'(a_rdata), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Pure round robin, all four reading, L=1.
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            a_v = 4'hF; a_we = 4'h0;
            for (int k = 0; k < 4; k++) a_addr[k*8 +: 8] = 8'(8'h20 + k);
            #1;
            chk($sformatf("t1_gnt%0d", c),  32'(a_r),     32'(4'h1 << (c % 4)));
            chk($sformatf("t1_addr%0d", c), 32'(za_addr), 32'(8'h20 + c % 4));
            chk($sformatf("t1_wen%0d", c),  32'(za_wen),  32'h1);
            if (c == 0) begin
                chk("t1_rv0", 32'(a_rv), 32'h0);
            end else begin
                chk($sformatf("t1_rv%0d", c),   32'(a_rv),    32'(4'h1 << ((c - 1) % 4)));
                chk($sformatf("t1_rdat%0d", c), 32'(a_rdata), 32'({8'hA5, 8'(8'h20 + (c - 1) % 4)}));
            end
        end
        @(negedge clk);
        a_v = 4'h0;
        #1;
        chk("t1_rv_last",  32'(a_rv),     32'h8);
        chk("t1_rd_last",  32'(a_rdata),  32'hA523);
        chk("idle_cen",    32'(za_cen),   32'h1);
        chk("idle_wen",    32'(za_wen),   32'h1);
        chk("idle_addr",   32'(za_addr),  32'h0);
        chk("idle_wdata",  32'(za_wdata), 32'h0);
        @(negedge clk);
        #1;
        chk("t1_rv_off",   32'(a_rv),    32'h0);
        chk("t1_rd_off",   32'(a_rdata), 32'h0);

        // Stall: req2 waits three cycles with i_z_r low.
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            a_v = 4'h4; a_we = 4'h0; a_addr[16 +: 8] = 8'h55; za_r = 1'b0;
            #1;
            chk($sformatf("t4_r%0d", s),    32'(a_r),     32'h0);
            chk($sformatf("t4_addr%0d", s), 32'(za_addr), 32'h55);
            chk($sformatf("t4_rv%0d", s),   32'(a_rv),    32'h0);
        end
        @(negedge clk);
        za_r = 1'b1;
        #1;
        chk("t4_accept", 32'(a_r), 32'h4);
        @(negedge clk);
        a_v = 4'hA; a_addr[8 +: 8] = 8'h61; a_addr[24 +: 8] = 8'h63;
        #1;
        chk("t4_rv2",   32'(a_rv),    32'h4);
        chk("t4_rd2",   32'(a_rdata), 32'hA555);
        chk("t4_pri3",  32'(a_r),     32'h8);
        @(negedge clk);
        #1;
        chk("t4_rv3",   32'(a_rv),    32'h8);
        chk("t4_rd3",   32'(a_rdata), 32'hA563);
        chk("t4_wrap1", 32'(a_r),     32'h2);
        @(negedge clk);
        a_v = 4'h0;
        #1;
        chk("t4_rv1",   32'(a_rv),    32'h2);
        chk("t4_rd1",   32'(a_rdata), 32'hA561);

        // Burst of four: req0 and req2 writing continuously.
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            b_v = 4'h5; b_we = 4'h5; b_addr[0 +: 8] = 8'hF0; b_addr[16 +: 8] = 8'hF2;
            #1;
            chk($sformatf("t2_gnt%0d", s), 32'(b_r),    32'(exp_t2[s]));
            chk($sformatf("t2_wen%0d", s), 32'(zb_wen), 32'h0);
        end

        // Owner drops after two accepts; req3 takes over at once with a fresh count.
        for (int s = 0; s < 7; s++) begin
            @(negedge clk);
            b_v = v_t3[s]; b_we = v_t3[s];
            #1;
            chk($sformatf("t3_gnt%0d", s), 32'(b_r), 32'(exp_t3[s]));
        end

        // Write then read the same word with L=3.
        @(negedge clk);
        b_v = 4'h2; b_we = 4'h2; b_addr[8 +: 8] = 8'h10; b_wdata[16 +: 16] = 16'hBEEF;
        #1;
        chk("t5_w_gnt",   32'(b_r),      32'h2);
        chk("t5_w_wen",   32'(zb_wen),   32'h0);
        chk("t5_w_addr",  32'(zb_addr),  32'h10);
        chk("t5_w_wdata", 32'(zb_wdata), 32'hBEEF);
        @(negedge clk);
        b_v = 4'h1; b_we = 4'h0; b_addr[0 +: 8] = 8'h10;
        #1;
        chk("t5_r_gnt",  32'(b_r),    32'h1);
        chk("t5_r_wen",  32'(zb_wen), 32'h1);
        chk("t5_r_addr", 32'(zb_addr), 32'h10);
        @(negedge clk);
        b_v = 4'h0;
        #1;
        chk("t5_rv_p1", 32'(b_rv), 32'h0);
        @(negedge clk);
        #1;
        chk("t5_rv_p2", 32'(b_rv), 32'h0);
        @(negedge clk);
        #1;
        chk("t5_rv_p3", 32'(b_rv),    32'h1);
        chk("t5_rdata", 32'(b_rdata), 32'hBEEF);
        @(negedge clk);
        #1;
        chk("t5_rv_p4", 32'(b_rv),    32'h0);
        chk("t5_rd_p4", 32'(b_rdata), 32'h0);

        // Two reads in flight, then async reset.
        @(negedge clk);
        b_v = 4'h4; b_we = 4'h0; b_addr[16 +: 8] = 8'h33;
        #1;
        chk("t6_gnt_a", 32'(b_r), 32'h4);
        @(negedge clk);
        b_addr[16 +: 8] = 8'h34;
        #1;
        chk("t6_gnt_b", 32'(b_r), 32'h4);
        @(negedge clk);
        b_v = 4'h0;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_rv",  32'(b_rv),   32'h0);
        chk("t6_rst_cen", 32'(zb_cen), 32'h1);
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            #1;
            chk($sformatf("t6_hold_rv%0d", s), 32'(b_rv), 32'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        b_v = 4'hA; b_we = 4'hA;
        #1;
        chk("t6_first_gnt", 32'(b_r),  32'h2);
        chk("t6_post_rv0",  32'(b_rv), 32'h0);
        @(negedge clk);
        b_v = 4'h0;
        #1;
        chk("t6_post_rv1", 32'(b_rv), 32'h0);
        @(negedge clk);
        #1;
        chk("t6_post_rv2", 32'(b_rv), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
